histogram_sequencer: RTL and testbench

Frame-level controller that drives the median-filter/histogram datapath (filter + projection histogram pair) once per binary frame. It accepts a frame-ready pulse from the image-capture side, issues the filter start, waits for filter completion, streams both projection histograms out, and extracts the peak bin and count of each axis. It then clears the histogram and reports a single result. It sits between the capture/frame-buffer logic and the histogram datapath, and is the only master of `start`, `readHistogram` and `clearHistogram`.

---
 rtl/histogram_sequencer_if.sv | 42 ++++
 rtl/histogram_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_histogram_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/histogram_sequencer_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// histogram_sequencer_if : frame/datapath handshake bundle of the sequencer
// Revision 1.0
// -----------------------------------------------------------------------------
interface histogram_sequencer_if;
  logic       frameReady;
  logic       busy;
  logic       frameDropped;
  logic       start;
  logic       filterReady;
  logic       filterDone;
  logic       readHistogram;
  logic       clearHistogram;
  logic [7:0] xHistogramOut;
  logic [7:0] yHistogramOut;
  logic       xValid;
  logic       yValid;
  logic       histogramClear;
  logic       ready;
  logic [7:0] xPeak;
  logic [7:0] yPeak;
  logic [7:0] xPeakCount;
  logic [7:0] yPeakCount;
  logic       resultValid;
  logic       timeoutError;

  modport master (
    input  frameReady, filterReady, filterDone, xHistogramOut, yHistogramOut,
           xValid, yValid, histogramClear, ready,
    output busy, frameDropped, start, readHistogram, clearHistogram,
           xPeak, yPeak, xPeakCount, yPeakCount, resultValid, timeoutError
  );

  modport slave (
    output frameReady, filterReady, filterDone, xHistogramOut, yHistogramOut,
           xValid, yValid, histogramClear, ready,
    input  busy, frameDropped, start, readHistogram, clearHistogram,
           xPeak, yPeak, xPeakCount, yPeakCount, resultValid, timeoutError
  );
endinterface
`default_nettype wire

// File: rtl/histogram_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// histogram_sequencer : per-frame filter start, histogram readout, peak extract
// Revision 1.0
// -----------------------------------------------------------------------------
module histogram_sequencer #(
  parameter int IMAGE_WIDTH    = 240,
  parameter int IMAGE_HEIGHT   = 180,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  reset,
  histogram_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    FILTER = 3'd2,
    READ   = 3'd3,
    CLEAR  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [8:0]  X_TOTAL  = 9'(IMAGE_WIDTH);
  localparam logic [8:0]  Y_TOTAL  = 9'(IMAGE_HEIGHT);
  localparam logic [19:0] WD_LIMIT = 20'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic        pending;
  logic        aborted;
  logic [19:0] wd_count;
  logic [8:0]  x_count;
  logic [8:0]  y_count;
  logic [8:0]  x_count_next;
  logic [8:0]  y_count_next;
  logic [7:0]  x_max_idx;
  logic [7:0]  x_max_val;
  logic [7:0]  y_max_idx;
  logic [7:0]  y_max_val;

  logic        start_pulse;
  logic        clear_pulse;
  logic        result_pulse;
  logic        timeout_pulse;
  logic        dropped_pulse;
  logic [7:0]  x_peak;
  logic [7:0]  x_peak_count;
  logic [7:0]  y_peak;
  logic [7:0]  y_peak_count;

  logic        wd_expired;
  logic        x_take;
  logic        y_take;
  logic        accept_frame;
  logic        timeout_next;

  assign wd_expired   = (wd_count == WD_LIMIT);
  assign x_take       = (state == READ) && bus.xValid && (x_count != X_TOTAL);
  assign y_take       = (state == READ) && bus.yValid && (y_count != Y_TOTAL);
  assign x_count_next = x_count + {8'd0, x_take};
  assign y_count_next = y_count + {8'd0, y_take};
  assign accept_frame = bus.frameReady && !pending && (state == IDLE);

  always_comb begin
    state_next   = state;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (pending && bus.filterReady && bus.ready) state_next = START;
      end
      START: begin
        state_next = FILTER;
      end
      FILTER: begin
        if (bus.filterDone) begin
          state_next = READ;
        end else if (wd_expired) begin
          state_next   = CLEAR;
          timeout_next = 1'b1;
        end
      end
      READ: begin
        // Leave on the same edge that counts the final bin
        if ((x_count_next == X_TOTAL) && (y_count_next == Y_TOTAL)) begin
          state_next = CLEAR;
        end else if (wd_expired) begin
          state_next   = CLEAR;
          timeout_next = 1'b1;
        end
      end
      CLEAR: begin
        // Completion is only trusted after the clear request has been issued
        if (!clear_pulse && bus.histogramClear) begin
          state_next = aborted ? IDLE : DONE;
        end else if (wd_expired) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending       <= 1'b0;
      wd_count      <= 20'd0;
      start_pulse   <= 1'b0;
      clear_pulse   <= 1'b0;
      result_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
      dropped_pulse <= 1'b0;
    end else begin
      if (accept_frame) begin
        pending <= 1'b1;
      end else if ((state == IDLE) && (state_next == START)) begin
        pending <= 1'b0;
      end

      if (state_next != state) begin
        wd_count <= 20'd0;
      end else if ((state == FILTER) || (state == READ) || (state == CLEAR)) begin
        wd_count <= wd_count + 20'd1;
      end else begin
        wd_count <= 20'd0;
      end

      dropped_pulse <= bus.frameReady && !accept_frame;
      start_pulse   <= (state_next == START) && (state != START);
      clear_pulse   <= (state_next == CLEAR) && (state != CLEAR);
      result_pulse  <= (state_next == DONE);
      timeout_pulse <= timeout_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_count   <= 9'd0;
      y_count   <= 9'd0;
      x_max_idx <= 8'd0;
      x_max_val <= 8'd0;
      y_max_idx <= 8'd0;
      y_max_val <= 8'd0;
      aborted   <= 1'b0;
    end else if (state == START) begin
      x_count   <= 9'd0;
      y_count   <= 9'd0;
      x_max_idx <= 8'd0;
      x_max_val <= 8'd0;
      y_max_idx <= 8'd0;
      y_max_val <= 8'd0;
      aborted   <= 1'b0;
    end else begin
      x_count <= x_count_next;
      y_count <= y_count_next;
      // Strictly-greater update keeps the lowest index on ties
      if (x_take && (bus.xHistogramOut > x_max_val)) begin
        x_max_val <= bus.xHistogramOut;
        x_max_idx <= x_count[7:0];
      end
      if (y_take && (bus.yHistogramOut > y_max_val)) begin
        y_max_val <= bus.yHistogramOut;
        y_max_idx <= y_count[7:0];
      end
      if (timeout_next && (state_next == CLEAR)) begin
        aborted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_peak       <= 8'd0;
      x_peak_count <= 8'd0;
      y_peak       <= 8'd0;
      y_peak_count <= 8'd0;
    end else if (state_next == DONE) begin
      x_peak       <= x_max_idx;
      x_peak_count <= x_max_val;
      y_peak       <= y_max_idx;
      y_peak_count <= y_max_val;
    end
  end

  assign bus.busy           = (state != IDLE) || pending;
  assign bus.frameDropped   = dropped_pulse;
  assign bus.start          = start_pulse;
  assign bus.readHistogram  = (state == READ);
  assign bus.clearHistogram = clear_pulse;
  assign bus.xPeak          = x_peak;
  assign bus.xPeakCount     = x_peak_count;
  assign bus.yPeak          = y_peak;
  assign bus.yPeakCount     = y_peak_count;
  assign bus.resultValid    = result_pulse;
  assign bus.timeoutError   = timeout_pulse;

endmodule
`default_nettype wire

// File: tb/tb_histogram_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_histogram_sequencer : scoreboard bench for the frame sequencer
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_histogram_sequencer;

  localparam int TIMEOUT = 600;

  typedef struct packed {
    logic       is_timeout;
    logic [7:0] xp;
    logic [7:0] xc;
    logic [7:0] yp;
    logic [7:0] yc;
  } exp_t;

  logic clk;
  logic reset;
  histogram_sequencer_if bus();

  histogram_sequencer #(
    .IMAGE_WIDTH   (240),
    .IMAGE_HEIGHT  (180),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  int   start_cnt = 0;
  int   clear_cnt = 0;
  int   drop_cnt = 0;
  int   result_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] xb[240];
  logic [7:0] yb[180];
  logic [7:0] last_xp, last_xc, last_yp, last_yc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Monitor: pulse counting plus scoreboard comparison on every reported event
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.start) start_cnt++;
      if (bus.clearHistogram) clear_cnt++;
      if (bus.frameDropped) drop_cnt++;
      if (bus.resultValid) result_cnt++;
      if (bus.resultValid || bus.timeoutError) begin
        check("event_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("event_kind", bus.timeoutError, mon_e.is_timeout);
          if (!mon_e.is_timeout) begin
            check("xPeak", bus.xPeak, mon_e.xp);
            check("xPeakCount", bus.xPeakCount, mon_e.xc);
            check("yPeak", bus.yPeak, mon_e.yp);
            check("yPeakCount", bus.yPeakCount, mon_e.yc);
          end
        end
      end
    end
  end

  task automatic kick();
    @(posedge clk); #1 bus.frameReady = 1'b1;
    @(posedge clk); #1 bus.frameReady = 1'b0;
    @(negedge clk);
    check("pending_busy", bus.busy, 1);
    check("start_early", bus.start, 0);
    @(negedge clk);
    check("start_latency", bus.start, 1);
  endtask

  task automatic filter_done(input int delay);
    repeat (delay) @(posedge clk);
    #1 bus.filterDone = 1'b1;
    @(posedge clk); #1 bus.filterDone = 1'b0;
    @(negedge clk);
    check("read_after_done", bus.readHistogram, 1);
  endtask

  task automatic stream(input bit conc, input int extra);
    int xi = 0;
    int yi = 0;
    int xn = 240 + extra;
    while (xi < xn || yi < 180) begin
      @(posedge clk); #1;
      bus.xValid = 1'b0;
      bus.yValid = 1'b0;
      if (xi < xn) begin
        bus.xValid = 1'b1;
        bus.xHistogramOut = (xi < 240) ? xb[xi] : 8'hFF;
        xi++;
      end
      if (yi < 180 && (conc || !bus.xValid)) begin
        bus.yValid = 1'b1;
        bus.yHistogramOut = yb[yi];
        yi++;
      end
    end
    @(posedge clk); #1;
    bus.xValid = 1'b0;
    bus.yValid = 1'b0;
  endtask

  task automatic finish_frame(input int fdelay, input bit conc, input int extra,
                              input logic [7:0] xp, input logic [7:0] xc,
                              input logic [7:0] yp, input logic [7:0] yc);
    exp_t e;
    int c0 = clear_cnt;
    int r0 = result_cnt;
    e.is_timeout = 1'b0;
    e.xp = xp; e.xc = xc; e.yp = yp; e.yc = yc;
    exp_q.push_back(e);
    filter_done(fdelay);
    stream(conc, extra);
    if (extra == 0) begin
      @(negedge clk);
      check("read_drop", bus.readHistogram, 0);
      check("clear_on_drop", bus.clearHistogram, 1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("peak_held_x", bus.xPeak, last_xp);
    check("peak_held_yc", bus.yPeakCount, last_yc);
    @(posedge clk); #1 bus.histogramClear = 1'b1;
    @(posedge clk); #1 bus.histogramClear = 1'b0;
    @(negedge clk);
    check("result_timing", bus.resultValid, 1);
    @(negedge clk);
    check("result_single", bus.resultValid, 0);
    check("clear_once", clear_cnt - c0, 1);
    check("result_once", result_cnt - r0, 1);
    last_xp = xp; last_xc = xc; last_yp = yp; last_yc = yc;
  endtask

  task automatic fill_nominal();
    for (int i = 0; i < 240; i++) xb[i] = 8'(i % 11);
    for (int i = 0; i < 180; i++) yb[i] = 8'((i * 7) % 10);
    xb[37] = 8'd200;
    yb[91] = 8'd150;
  endtask

  task automatic fill_ties();
    for (int i = 0; i < 240; i++) xb[i] = 8'(i % 7);
    for (int i = 0; i < 180; i++) yb[i] = 8'd0;
    xb[12] = 8'd99;
    xb[80] = 8'd99;
  endtask

  task automatic fill_conc();
    for (int i = 0; i < 240; i++) xb[i] = 8'((i * 3) % 50);
    for (int i = 0; i < 180; i++) yb[i] = 8'(i % 20);
    xb[200] = 8'd180;
    yb[179] = 8'd60;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got still running, required finished");
    $fatal(1, "bench stopped by time limit");
  end

  initial begin
    exp_t e;
    int s0, d0, r0;
    reset = 1'b1;
    bus.frameReady = 1'b0;
    bus.filterReady = 1'b1;
    bus.filterDone = 1'b0;
    bus.xHistogramOut = 8'd0;
    bus.yHistogramOut = 8'd0;
    bus.xValid = 1'b0;
    bus.yValid = 1'b0;
    bus.histogramClear = 1'b0;
    bus.ready = 1'b1;
    last_xp = 8'd0; last_xc = 8'd0; last_yp = 8'd0; last_yc = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_start", bus.start, 0);
    check("rst_read", bus.readHistogram, 0);
    check("rst_clear", bus.clearHistogram, 0);
    check("rst_result", bus.resultValid, 0);
    check("rst_timeout", bus.timeoutError, 0);
    check("rst_peaks", {bus.xPeak, bus.xPeakCount, bus.yPeak, bus.yPeakCount}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Nominal frame
    fill_nominal();
    kick();
    finish_frame(50, 1'b0, 0, 8'd37, 8'd200, 8'd91, 8'd150);

    // Ties and all-zero axis, with surplus x strobes landing inside READ
    fill_ties();
    kick();
    finish_frame(5, 1'b0, 5, 8'd12, 8'd99, 8'd0, 8'd0);

    // Concurrent strobes, surplus x strobes after completion, peak in last y bin
    fill_conc();
    s0 = start_cnt;
    kick();
    finish_frame(3, 1'b1, 5, 8'd200, 8'd180, 8'd179, 8'd60);
    check("conc_start_once", start_cnt - s0, 1);

    // Back-pressure from the histogram and a dropped second frame
    fill_nominal();
    bus.ready = 1'b0;
    s0 = start_cnt;
    d0 = drop_cnt;
    @(posedge clk); #1 bus.frameReady = 1'b1;
    @(posedge clk); #1 bus.frameReady = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.frameReady = 1'b1;
    @(posedge clk); #1 bus.frameReady = 1'b0;
    repeat (10) @(negedge clk);
    check("bp_busy", bus.busy, 1);
    check("bp_no_start", start_cnt - s0, 0);
    check("bp_dropped", drop_cnt - d0, 1);
    @(posedge clk); #1 bus.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_start", bus.start, 1);
    finish_frame(8, 1'b0, 0, 8'd37, 8'd200, 8'd91, 8'd150);

    // Watchdog in FILTER: no result, previous peaks kept
    e = '0;
    e.is_timeout = 1'b1;
    exp_q.push_back(e);
    r0 = result_cnt;
    kick();
    repeat (TIMEOUT) @(negedge clk);
    check("wd_not_early", bus.timeoutError, 0);
    @(negedge clk);
    check("wd_fire", bus.timeoutError, 1);
    check("wd_clear", bus.clearHistogram, 1);
    repeat (2) @(posedge clk);
    #1 bus.histogramClear = 1'b1;
    @(posedge clk); #1 bus.histogramClear = 1'b0;
    repeat (5) @(negedge clk);
    check("wd_no_result", result_cnt - r0, 0);
    check("wd_idle", bus.busy, 0);
    check("wd_held_x", {bus.xPeak, bus.xPeakCount}, {8'd37, 8'd200});
    check("wd_held_y", {bus.yPeak, bus.yPeakCount}, {8'd91, 8'd150});

    // Reset in the middle of READ, then a clean frame
    fill_ties();
    kick();
    filter_done(10);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      bus.xValid = 1'b1;
      bus.xHistogramOut = 8'(i);
    end
    @(posedge clk); #1;
    bus.xValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_read", bus.readHistogram, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_peaks", {bus.xPeak, bus.xPeakCount, bus.yPeak, bus.yPeakCount}, 0);
    @(posedge clk); #1 reset = 1'b0;
    last_xp = 8'd0; last_xc = 8'd0; last_yp = 8'd0; last_yc = 8'd0;
    kick();
    finish_frame(4, 1'b0, 0, 8'd12, 8'd99, 8'd0, 8'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
